// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: start/done handshake plus operand and result bundle for muldiv_unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;
  modport master(output start, op, cancel, a, b, input hi, lo, busy, done, div_zero);
  modport slave(input start, op, cancel, a, b, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multicycle signed/unsigned multiply (shift-add) and divide (restoring), one bit per clock
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             r_state, w_next;
  logic               r_isdiv, r_sa, r_sb, r_dz, r_done, r_div0;
  logic [WIDTH-1:0]   r_a, r_m, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_p;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_start, w_bz, w_sa, w_sb, w_neg;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_q, w_r;
  logic [WIDTH:0]     w_sum, w_sh;
  logic [WIDTH+1:0]   w_dif;
  logic [2*WIDTH-1:0] w_pm, w_pd, w_prod;
  assign w_sa    = ~bus.op[0] & bus.a[WIDTH-1];
  assign w_sb    = ~bus.op[0] & bus.b[WIDTH-1];
  assign w_abs_a = w_sa ? -bus.a : bus.a;
  assign w_abs_b = w_sb ? -bus.b : bus.b;
  assign w_start = (r_state == IDLE) & bus.start & ~bus.cancel;
  assign w_bz    = bus.op[1] & (bus.b == '0);
  assign w_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
  assign w_pm    = r_p[0] ? {w_sum, r_p[WIDTH-1:1]} : {1'b0, r_p[2*WIDTH-1:1]};
  assign w_sh    = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_dif   = {1'b0, w_sh} - {2'b0, r_m};
  assign w_pd    = w_dif[WIDTH+1] ? {w_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                                  : {w_dif[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
  assign w_neg   = r_sa ^ r_sb;
  assign w_prod  = w_neg ? -r_p : r_p;
  assign w_q     = w_neg ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_r     = r_sa ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = r_state != IDLE;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div0;
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: divide by zero skips the iterations, cancel aborts RUN/FIX
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) begin
      if (w_start) w_next = w_bz ? FIX : RUN;
    end else if (bus.cancel) w_next = IDLE;
    else if (r_state == RUN) begin
      if (r_cnt == CNT_W'(WIDTH - 1)) w_next = FIX;
    end else w_next = IDLE;
  end
  // operand latch, per-bit iteration and sign-corrected result registration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_isdiv <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
      r_a     <= '0;
      r_m     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_isdiv <= bus.op[1];
        r_sa    <= w_sa;
        r_sb    <= w_sb;
        r_dz    <= w_bz;
        r_a     <= bus.a;
        r_m     <= bus.op[1] ? w_abs_b : w_abs_a;
        r_p     <= {{WIDTH{1'b0}}, bus.op[1] ? w_abs_a : w_abs_b};
        r_cnt   <= '0;
        r_div0  <= 1'b0;
      end else if (r_state == RUN && !bus.cancel) begin
        r_p   <= r_isdiv ? w_pd : w_pm;
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state == FIX && !bus.cancel) begin
        r_hi   <= r_dz ? r_a : r_isdiv ? w_r : w_prod[2*WIDTH-1:WIDTH];
        r_lo   <= r_dz ? '1 : r_isdiv ? w_q : w_prod[WIDTH-1:0];
        r_done <= 1'b1;
        r_div0 <= r_dz;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit at WIDTH=32
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat, nd, d1, d2;
  muldiv_unit_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int l);
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    l = 0;
    while (!bus.done && l < 100) begin
      @(negedge clk);
      l++;
    end
  endtask
  task automatic idle_no_done(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    #22;
    chk("reset_out", {bus.hi, bus.lo}, 64'd0);
    chk("reset_flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(2'b00, 32'hFFFFFFFD, 32'd7, lat);
    chk("mult_lat", 64'(lat), 64'd33);
    chk("mult_res", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
    chk("mult_busy", {62'd0, bus.busy, bus.div_zero}, 64'd0);
    @(negedge clk);
    chk("done_pulse", {63'd0, bus.done}, 64'd0);
    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("multu_max", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    run(2'b01, 32'h00010000, 32'h00010000, lat);
    chk("multu_carry", {bus.hi, bus.lo}, 64'h00000001_00000000);
    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("mult_negneg", {bus.hi, bus.lo}, 64'h00000000_00000001);
    run(2'b10, 32'hFFFFFFF9, 32'd2, lat);
    chk("div_lat", 64'(lat), 64'd33);
    chk("div_neg", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    run(2'b10, 32'd7, 32'hFFFFFFFE, lat);
    chk("div_negb", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFD);
    run(2'b11, 32'd7, 32'd2, lat);
    chk("divu", {bus.hi, bus.lo}, 64'h00000001_00000003);
    run(2'b10, 32'h80000000, 32'hFFFFFFFF, lat);
    chk("div_min", {bus.hi, bus.lo}, 64'h00000000_80000000);
    chk("div_min_flag", {63'd0, bus.div_zero}, 64'd0);
    run(2'b10, 32'h00001234, 32'd0, lat);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_res", {bus.hi, bus.lo}, 64'h00001234_FFFFFFFF);
    chk("dz_flag", {63'd0, bus.div_zero}, 64'd1);
    @(negedge clk);
    chk("dz_hold", {62'd0, bus.div_zero, bus.done}, 64'd2);
    run(2'b10, 32'hFFFFFFF9, 32'd0, lat);
    chk("dz_signed", {bus.hi, bus.lo}, 64'hFFFFFFF9_FFFFFFFF);
    bus.op = 2'b11;
    bus.a = 32'd7;
    bus.b = 32'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("dz_clear", {62'd0, bus.busy, bus.div_zero}, 64'd2);
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("divu_after_dz", {bus.hi, bus.lo}, 64'h00000001_00000003);
    @(negedge clk);
    nd = 0;
    d1 = -1;
    d2 = -1;
    bus.op = 2'b01;
    bus.a = 32'd3;
    bus.b = 32'd5;
    bus.start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (nd == 0) d1 = c;
        else if (nd == 1) d2 = c;
        nd++;
        chk("held_lo", {bus.hi, bus.lo}, 64'd15);
      end
      if (c == 39) bus.start = 1'b0;
    end
    chk("held_d1", 64'(d1), 64'd33);
    chk("held_d2", 64'(d2), 64'd67);
    chk("held_nd", 64'(nd), 64'd2);
    bus.op = 2'b00;
    bus.a = 32'hFFFFFFFD;
    bus.b = 32'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("cancel_busy_pre", {63'd0, bus.busy}, 64'd1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_busy", {63'd0, bus.busy}, 64'd0);
    idle_no_done("cancel_nodone", 40);
    chk("cancel_keep", {bus.hi, bus.lo}, 64'd15);
    bus.cancel = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    bus.start = 1'b0;
    chk("cancel_idle", {63'd0, bus.busy}, 64'd0);
    idle_no_done("cancel_idle_nd", 40);
    bus.op = 2'b01;
    bus.a = 32'hFFFFFFFF;
    bus.b = 32'hFFFFFFFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_out", {bus.hi, bus.lo}, 64'd0);
    chk("rst_mid_flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_no_done("rst_nodone", 40);
    run(2'b11, 32'd7, 32'd2, lat);
    chk("rst_after_lat", 64'(lat), 64'd33);
    chk("rst_after_res", {bus.hi, bus.lo}, 64'h00000001_00000003);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
